// File: rtl/shufflev_pkg.sv
// Shared constants and types for the shufflev fetch path.
// LFSR polynomial x^8+x^6+x^5+x^4+1 and the response entry bundle.
package shufflev_pkg;

  localparam int LfsrWidth = 8;
  localparam logic [LfsrWidth-1:0] LfsrTaps = 8'hB8;
  localparam logic [LfsrWidth-1:0] LfsrSeedDefault = 8'hA5;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_entry_t;

endpackage

// File: rtl/shufflev_lfsr.sv
// Free-running Fibonacci LFSR, shifts left with feedback into bit 0.
// Shared with the shuffling buffer's random pointer logic.
module shufflev_lfsr
  import shufflev_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] Seed = LfsrSeedDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic [LfsrWidth-1:0] lfsr_o
);

  logic [LfsrWidth-1:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= {lfsr_q[LfsrWidth-2:0], ^(lfsr_q & LfsrTaps)};
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/shufflev_imem_responder.sv
// Instruction memory responder: grants fetches, reads a synchronous
// memory and returns in-order responses a fixed Latency after grant.
module shufflev_imem_responder
  import shufflev_pkg::*;
#(
  parameter logic [31:0] MemBase        = 32'h0010_0000,
  parameter int unsigned MemSize        = 65536,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          StallEn        = 1'b0,
  parameter logic [7:0]  LfsrSeed       = LfsrSeedDefault
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         instr_req_i,
  output logic                         instr_gnt_o,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  output logic                         mem_req_o,
  output logic [$clog2(MemSize)-3:0]   mem_addr_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         busy_o
);

  localparam int AddrW = $clog2(MemSize) - 2;
  localparam logic [2:0] MaxOut = 3'(MaxOutstanding);

  logic [LfsrWidth-1:0] lfsr;
  logic                 stall;
  logic [31:0]          offset;
  logic                 in_range;
  logic [2:0]           cnt_q;
  logic [2:0]           cnt_eff;
  logic                 s1_vld_q;
  logic                 s1_err_q;
  resp_entry_t          s1;
  resp_entry_t          resp;
  logic                 unused_lfsr;

  shufflev_lfsr #(
    .Seed (LfsrSeed)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .lfsr_o (lfsr)
  );

  assign unused_lfsr = ^lfsr[LfsrWidth-1:1];
  assign stall = StallEn & lfsr[0];

  // Offset compare avoids overflow of MemBase+MemSize near the top of space.
  assign offset   = instr_addr_i - MemBase;
  assign in_range = (instr_addr_i >= MemBase) && (offset < MemSize);

  // A response leaving this cycle frees its slot for a same-cycle grant.
  assign cnt_eff     = cnt_q - 3'(instr_rvalid_o);
  assign instr_gnt_o = instr_req_i && (cnt_eff < MaxOut) && !stall;

  assign mem_req_o  = instr_gnt_o && in_range;
  assign mem_addr_o = offset[AddrW+1:2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_eff + 3'(instr_gnt_o);
      s1_vld_q <= instr_gnt_o;
      s1_err_q <= instr_gnt_o && !in_range;
    end
  end

  assign s1 = '{
    valid: s1_vld_q,
    err:   s1_err_q,
    data:  (s1_vld_q && !s1_err_q) ? mem_rdata_i : 32'h0
  };

  if (Latency == 1) begin : g_direct
    assign resp = s1;
  end else begin : g_delay
    logic [Latency-2:0] vld_q;
    logic [Latency-2:0] err_q;
    logic [31:0]        dat_q [Latency-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= s1.valid;
        for (int k = 1; k < Latency - 1; k++) begin
          vld_q[k] <= vld_q[k-1];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      err_q[0] <= s1.err;
      dat_q[0] <= s1.data;
      for (int k = 1; k < Latency - 1; k++) begin
        err_q[k] <= err_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
    end

    assign resp = '{
      valid: vld_q[Latency-2],
      err:   err_q[Latency-2],
      data:  dat_q[Latency-2]
    };
  end

  assign instr_rvalid_o = resp.valid;
  assign instr_err_o    = resp.valid && resp.err;
  assign instr_rdata_o  = resp.valid ? resp.data : 32'h0;
  assign busy_o         = (cnt_q != 3'd0);

endmodule

// File: tb/tb_shufflev_imem_responder.sv
// Bench for shufflev_imem_responder: four configurations share a clock,
// a scoreboard checks every response's data, error and grant-relative timing.
module tb_shufflev_imem_responder;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int LAT [4] = '{1, 3, 1, 2};

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n  [4];
  logic        req    [4];
  logic [31:0] addr   [4];
  logic        gnt    [4];
  logic        rvalid [4];
  logic [31:0] rdata  [4];
  logic        err    [4];
  logic        mreq   [4];
  logic [13:0] maddr  [4];
  logic [31:0] mdata  [4];
  logic        busy   [4];

  exp_t sb [4][$];
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  logic [7:0] lfsr_m;
  logic rst2;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    shufflev_imem_responder #(
      .MemBase        (BASE),
      .MemSize        (65536),
      .Latency        (LAT[g]),
      .MaxOutstanding (2),
      .StallEn        (g == 2),
      .LfsrSeed       (8'hA5)
    ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n[g]),
      .instr_req_i    (req[g]),
      .instr_gnt_o    (gnt[g]),
      .instr_addr_i   (addr[g]),
      .instr_rvalid_o (rvalid[g]),
      .instr_rdata_o  (rdata[g]),
      .instr_err_o    (err[g]),
      .mem_req_o      (mreq[g]),
      .mem_addr_o     (maddr[g]),
      .mem_rdata_i    (mdata[g]),
      .busy_o         (busy[g])
    );
  end

  function automatic logic [31:0] mem_word(input logic [13:0] w);
    if (w == 14'd0) return 32'h0000_0013;
    return {2'b10, w, 2'b01, ~w};
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h0001_0000);
  endfunction

  function automatic logic [13:0] widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o[15:2];
  endfunction

  // Synchronous memory model; garbage when not strobed the cycle before.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      mdata[i] <= mreq[i] ? mem_word(maddr[i]) : 32'hDEAD_BEEF;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign rst2 = rst_n[2];
  always @(posedge clk or negedge rst2) begin
    if (!rst2) lfsr_m <= 8'hA5;
    else lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    logic em;
    for (int i = 0; i < 4; i++) begin
      if (rst_n[i]) begin
        nchk++;
        if (rvalid[i]) begin
          if (sb[i].size() == 0) begin
            nerr++;
            $display("FAIL sb_unexpected dut%0d cyc=%0d rdata=%h", i, cyc, rdata[i]);
          end else begin
            e = sb[i].pop_front();
            if (rdata[i] !== e.data || err[i] !== e.err || cyc !== e.cyc + LAT[i]) begin
              nerr++;
              $display("FAIL sb_resp dut%0d got d=%h e=%b c=%0d want d=%h e=%b c=%0d",
                       i, rdata[i], err[i], cyc, e.data, e.err, e.cyc + LAT[i]);
            end
          end
        end else if (rdata[i] !== 32'h0 || err[i] !== 1'b0) begin
          nerr++;
          $display("FAIL idle_zero dut%0d rdata=%h err=%b want 0", i, rdata[i], err[i]);
        end
        nchk++;
        em = gnt[i] && in_rng(addr[i]);
        if (mreq[i] !== em || (em && maddr[i] !== widx(addr[i])) || (gnt[i] && !req[i])) begin
          nerr++;
          $display("FAIL mem_req dut%0d got req=%b addr=%h want req=%b addr=%h",
                   i, mreq[i], maddr[i], em, widx(addr[i]));
        end
        if (gnt[i]) begin
          e.cyc  = cyc;
          e.err  = !in_rng(addr[i]);
          e.data = in_rng(addr[i]) ? mem_word(widx(addr[i])) : 32'h0;
          sb[i].push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (rvalid[i] !== 1'b0 || busy[i] !== 1'b0 || rdata[i] !== 32'h0 || err[i] !== 1'b0) begin
        nerr++;
        $display("FAIL reset_state dut%0d rv=%b busy=%b d=%h e=%b want all 0",
                 i, rvalid[i], busy[i], rdata[i], err[i]);
      end
    end
  endtask

  task automatic test_basic();
    req[0] = 1'b1;
    addr[0] = BASE;
    @(negedge clk);
    nchk++;
    if (gnt[0] !== 1'b1 || mreq[0] !== 1'b1 || maddr[0] !== 14'd0) begin
      nerr++;
      $display("FAIL basic_gnt got gnt=%b mreq=%b maddr=%h want 1 1 0", gnt[0], mreq[0], maddr[0]);
    end
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    nchk++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h0000_0013 || err[0] !== 1'b0) begin
      nerr++;
      $display("FAIL basic_resp got rv=%b d=%h e=%b want 1 00000013 0", rvalid[0], rdata[0], err[0]);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    req[0] = 1'b1;
    addr[0] = 32'h0000_0000;
    @(negedge clk);
    nchk++;
    if (gnt[0] !== 1'b1 || mreq[0] !== 1'b0) begin
      nerr++;
      $display("FAIL oor_gnt got gnt=%b mreq=%b want 1 0", gnt[0], mreq[0]);
    end
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    nchk++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h0 || err[0] !== 1'b1) begin
      nerr++;
      $display("FAIL oor_resp got rv=%b d=%h e=%b want 1 0 1", rvalid[0], rdata[0], err[0]);
    end
    tick();
  endtask

  task automatic test_boundary();
    logic [31:0] ta [4];
    logic        te [4];
    logic [31:0] td [4];
    ta = '{32'h0010_FFFC, 32'h0011_0000, 32'h000F_FFFC, 32'h0010_0007};
    te = '{1'b0, 1'b1, 1'b1, 1'b0};
    td = '{mem_word(14'h3FFF), 32'h0, 32'h0, mem_word(14'd1)};
    for (int k = 0; k < 4; k++) begin
      req[0] = 1'b1;
      addr[0] = ta[k];
      tick();
      req[0] = 1'b0;
      @(negedge clk);
      nchk++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== td[k] || err[0] !== te[k]) begin
        nerr++;
        $display("FAIL boundary a=%h got rv=%b d=%h e=%b want 1 %h %b",
                 ta[k], rvalid[0], rdata[0], err[0], td[k], te[k]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      req[0] = 1'b1;
      addr[0] = BASE + 32'(k * 148);
      @(negedge clk);
      nchk++;
      if (gnt[0] !== 1'b1 || (k > 0 && rvalid[0] !== 1'b1)) begin
        nerr++;
        $display("FAIL b2b k=%0d got gnt=%b rv=%b want 1 %b", k, gnt[0], rvalid[0], k > 0);
      end
      tick();
    end
    req[0] = 1'b0;
    @(negedge clk);
    nchk++;
    if (rvalid[0] !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_last got rv=%b want 1", rvalid[0]);
    end
    tick();
  endtask

  task automatic test_outstanding_limit();
    logic eg [8];
    logic ev [8];
    int   r;
    int   nr;
    eg = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    r = 0;
    nr = 0;
    for (int c = 0; c < 8; c++) begin
      req[1] = (r < 3);
      addr[1] = BASE + 32'(4 * r);
      @(negedge clk);
      nchk++;
      if (gnt[1] !== eg[c] || rvalid[1] !== ev[c]) begin
        nerr++;
        $display("FAIL limit c=%0d got gnt=%b rv=%b want %b %b", c, gnt[1], rvalid[1], eg[c], ev[c]);
      end
      if (rvalid[1] === 1'b1) begin
        nchk++;
        if (rdata[1] !== mem_word(14'(nr))) begin
          nerr++;
          $display("FAIL limit_order c=%0d got %h want %h", c, rdata[1], mem_word(14'(nr)));
        end
        nr++;
      end
      if (gnt[1] === 1'b1) r++;
      tick();
    end
    req[1] = 1'b0;
  endtask

  task automatic test_stall();
    int ng;
    int nv;
    ng = 0;
    nv = 0;
    for (int k = 0; k < 64; k++) begin
      req[2] = 1'b1;
      addr[2] = BASE + 32'(4 * (k % 16));
      @(negedge clk);
      nchk++;
      if (gnt[2] !== !lfsr_m[0]) begin
        nerr++;
        $display("FAIL stall k=%0d got gnt=%b want %b", k, gnt[2], !lfsr_m[0]);
      end
      if (gnt[2] === 1'b1) ng++;
      if (rvalid[2] === 1'b1) nv++;
      tick();
    end
    req[2] = 1'b0;
    @(negedge clk);
    if (rvalid[2] === 1'b1) nv++;
    nchk++;
    if (nv !== ng || ng == 0) begin
      nerr++;
      $display("FAIL stall_count got resp=%0d want %0d (grants)", nv, ng);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req[3] = 1'b1;
    addr[3] = BASE + 32'd8;
    @(negedge clk);
    nchk++;
    if (gnt[3] !== 1'b1) begin
      nerr++;
      $display("FAIL rmid_gnt got %b want 1", gnt[3]);
    end
    tick();
    req[3] = 1'b0;
    rst_n[3] = 1'b0;
    sb[3].delete();
    tick();
    tick();
    rst_n[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nchk++;
      if (rvalid[3] !== 1'b0 || busy[3] !== 1'b0) begin
        nerr++;
        $display("FAIL rmid_quiet k=%0d got rv=%b busy=%b want 0 0", k, rvalid[3], busy[3]);
      end
      tick();
    end
    req[3] = 1'b1;
    addr[3] = BASE + 32'h0C;
    @(negedge clk);
    nchk++;
    if (gnt[3] !== 1'b1) begin
      nerr++;
      $display("FAIL rmid_regnt got %b want 1", gnt[3]);
    end
    tick();
    req[3] = 1'b0;
    @(negedge clk);
    nchk++;
    if (busy[3] !== 1'b1 || rvalid[3] !== 1'b0) begin
      nerr++;
      $display("FAIL rmid_busy got busy=%b rv=%b want 1 0", busy[3], rvalid[3]);
    end
    tick();
    @(negedge clk);
    nchk++;
    if (rvalid[3] !== 1'b1 || rdata[3] !== mem_word(14'd3) || err[3] !== 1'b0) begin
      nerr++;
      $display("FAIL rmid_resp got rv=%b d=%h e=%b want 1 %h 0", rvalid[3], rdata[3], err[3], mem_word(14'd3));
    end
    tick();
  endtask

  task automatic test_drain();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 20 && !idle; k++) begin
      tick();
      idle = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (sb[i].size() != 0 || busy[i] !== 1'b0) idle = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (sb[i].size() != 0 || busy[i] !== 1'b0) begin
        nerr++;
        $display("FAIL drain dut%0d got pending=%0d busy=%b want 0 0", i, sb[i].size(), busy[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0;
      req[i] = 1'b0;
      addr[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    test_reset();
    tick();
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    tick();
    test_basic();
    test_out_of_range();
    test_boundary();
    test_back_to_back();
    test_outstanding_limit();
    test_stall();
    test_reset_mid();
    test_drain();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
